// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: bundle between a multiplexed 7-segment display bus
// and the scan decoder that reads it back.
//   segment     : active-low segment bus, bit7 = dp, bits6:0 = g..a
//   an_val      : active-low anode selects, bit i low = position i lit
//   digits      : committed hex value per position, position i at [4i+3:4i]
//   digit_valid : position holds a committed non-blank digit
//   dp          : committed decimal-point state per position (1 = lit)
//   update      : one-cycle pulse when any committed value/valid/dp changes
//   error       : one-cycle pulse on an undecodable pattern or multi-hot anode
// master = display/driver side, slave = decoder side.
interface seg_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [7:0]              segment;
  logic [NUM_DIGITS-1:0]   an_val;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    update;
  logic                    error;

  modport master (
    output segment, an_val,
    input  digits, digit_valid, dp, update, error
  );

  modport slave (
    input  segment, an_val,
    output digits, digit_valid, dp, update, error
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a multiplexed, active-low 7-segment bus and
// recovers the digit shown on each anode position. Each anode activation is
// sampled once after it has been stable for SETTLE_CYCLES; a position commits
// only after CONFIRM_SCANS consecutive identical samples.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : seg_scan_decoder_if.slave (segment, an_val in; digits,
//           digit_valid, dp, update, error out)
// Optional build macro: SEG_HEX_DECODE_EN -- when defined, the A..F patterns
// decode to 10..15; otherwise they are treated as undecodable.
module seg_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CONFIRM_SCANS = 2
) (
  input logic               clock,
  input logic               reset,
  seg_scan_decoder_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_TGT  = CNT_W'(SETTLE_CYCLES);
  localparam logic [3:0]       CONFIRM_TGT = 4'(CONFIRM_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] an_d1;

  logic [3:0]            cand_val  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] cand_blank;
  logic [NUM_DIGITS-1:0] cand_dp;
  logic [3:0]            match_cnt [NUM_DIGITS];
  logic [3:0]            dig_q     [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic                  update_q;
  logic                  error_q;

  logic                  an_changed;
  logic                  an_idle;
  logic                  an_onehot;
  logic [NUM_DIGITS-1:0] an_low;
  logic [IDX_W-1:0]      pos;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  sample_now;
  logic                  dec_ok;
  logic                  dec_blank;
  logic                  dec_dp;
  logic [3:0]            dec_val;
  logic                  cand_same;
  logic [NUM_DIGITS-1:0] commit;

  assign an_low     = ~an_q;
  assign an_changed = (an_q != an_d1);
  assign an_idle    = &an_q;
  assign an_onehot  = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign cnt_inc    = cnt + CNT_W'(1);

  // The sample is taken on the edge where the stable count reaches
  // SETTLE_CYCLES, so with SETTLE_CYCLES == 1 the entry edge itself samples.
  assign sample_now = an_changed ? (an_onehot && (SETTLE_TGT == CNT_W'(1)))
                                 : ((state == S_SETTLE) && (cnt_inc == SETTLE_TGT));

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) pos = IDX_W'(i);
    end
  end

  assign dec_dp = ~seg_q[7];

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_val   = '0;
    case (seg_q[6:0])
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
`ifdef SEG_HEX_DECODE_EN
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
`endif
      7'h7F: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  assign cand_same = (cand_val[pos] == dec_val) && (cand_blank[pos] == dec_blank) &&
                     (cand_dp[pos] == dec_dp);

  // A confirmed blank only owns digit_valid and dp; its value field is ignored.
  always_comb begin
    commit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (match_cnt[i] == CONFIRM_TGT) begin
        if (cand_blank[i]) commit[i] = valid_q[i] || (dp_q[i] != cand_dp[i]);
        else commit[i] = !valid_q[i] || (dig_q[i] != cand_val[i]) || (dp_q[i] != cand_dp[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q      <= '1;
      an_q       <= '1;
      an_d1      <= '1;
      state      <= S_IDLE;
      cnt        <= '0;
      cand_blank <= '0;
      cand_dp    <= '0;
      valid_q    <= '0;
      dp_q       <= '0;
      update_q   <= 1'b0;
      error_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        cand_val[i]  <= '0;
        match_cnt[i] <= '0;
        dig_q[i]     <= '0;
      end
    end else begin
      seg_q <= bus.segment;
      an_q  <= bus.an_val;
      an_d1 <= an_q;

      if (an_changed) begin
        if (an_onehot) begin
          cnt   <= CNT_W'(1);
          state <= sample_now ? S_HOLD : S_SETTLE;
        end else begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      end else if (state == S_SETTLE) begin
        cnt <= cnt_inc;
        if (sample_now) state <= S_HOLD;
      end

      error_q <= (an_changed && !an_idle && !an_onehot) || (sample_now && !dec_ok);

      if (sample_now && dec_ok) begin
        if (cand_same) begin
          if (match_cnt[pos] != CONFIRM_TGT) match_cnt[pos] <= match_cnt[pos] + 4'd1;
        end else begin
          cand_val[pos]   <= dec_val;
          cand_blank[pos] <= dec_blank;
          cand_dp[pos]    <= dec_dp;
          match_cnt[pos]  <= 4'd1;
        end
      end

      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (commit[i]) begin
          valid_q[i] <= !cand_blank[i];
          dp_q[i]    <= cand_dp[i];
          if (!cand_blank[i]) dig_q[i] <= cand_val[i];
        end
      end
      update_q <= |commit;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
    assign bus.digits[4*g +: 4] = dig_q[g];
  end

  assign bus.digit_valid = valid_q;
  assign bus.dp          = dp_q;
  assign bus.update      = update_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table of anode activations with expected outputs,
// plus a commit scoreboard popped on every update pulse, and a hand-written
// reset/latency sequence.
`timescale 1ns/1ps
module tb_seg_scan_decoder;
  localparam int unsigned ND      = 4;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned CONFIRM = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_decoder #(
    .NUM_DIGITS(ND),
    .SETTLE_CYCLES(SETTLE),
    .CONFIRM_SCANS(CONFIRM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int unsigned hold;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  dp;
    int unsigned upd;
    int unsigned err;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  dp;
  } commit_t;

  vec_t    vecs[$];
  commit_t sb_q[$];
  int unsigned errors  = 0;
  int unsigned checks  = 0;
  int unsigned upd_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    commit_t e;
    if (!reset) begin
      if (bus.error) err_cnt++;
      if (bus.update) begin
        upd_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got update=1 expected no update (digits=%0h valid=%0b)",
                   bus.digits, bus.digit_valid);
        end else begin
          e = sb_q.pop_front();
          check("sb_digits", 32'(bus.digits), 32'(e.digits));
          check("sb_valid", 32'(bus.digit_valid), 32'(e.valid));
          check("sb_dp", 32'(bus.dp), 32'(e.dp));
        end
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    int unsigned u0 = upd_cnt;
    int unsigned e0 = err_cnt;
    commit_t c;
    if (v.upd != 0) begin
      c.digits = v.digits;
      c.valid  = v.valid;
      c.dp     = v.dp;
      sb_q.push_back(c);
    end
    bus.an_val  = v.an;
    bus.segment = v.seg;
    repeat (v.hold) tick();
    bus.an_val = '1;
    repeat (3) tick();
    check($sformatf("step%0d_digits", idx), 32'(bus.digits), 32'(v.digits));
    check($sformatf("step%0d_valid", idx), 32'(bus.digit_valid), 32'(v.valid));
    check($sformatf("step%0d_dp", idx), 32'(bus.dp), 32'(v.dp));
    check($sformatf("step%0d_updates", idx), upd_cnt - u0, v.upd);
    check($sformatf("step%0d_errors", idx), err_cnt - e0, v.err);
    check($sformatf("step%0d_sb_pending", idx), sb_q.size(), 0);
  endtask

  initial begin
    int unsigned u0;
    int unsigned e0;
    commit_t c;

    // an, seg, hold, digits, valid, dp, updates, errors
    vecs.push_back('{4'b1101, 8'hF9, 20, 16'h0000, 4'b0000, 4'b0000, 0, 0});
    vecs.push_back('{4'b1110, 8'hC0, 20, 16'h0000, 4'b0000, 4'b0000, 0, 0});
    vecs.push_back('{4'b1101, 8'hF9, 20, 16'h0010, 4'b0010, 4'b0000, 1, 0});
    vecs.push_back('{4'b1110, 8'hC0, 20, 16'h0010, 4'b0011, 4'b0000, 1, 0});
    vecs.push_back('{4'b1101, 8'hF9, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    vecs.push_back('{4'b1110, 8'hC0, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    vecs.push_back('{4'b1101, 8'hF9, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    // one-off glitch to "2" on position 1, then back to "1": no commit
    vecs.push_back('{4'b1101, 8'hA4, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    vecs.push_back('{4'b1101, 8'hF9, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    vecs.push_back('{4'b1101, 8'hF9, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    // activation one cycle short of the settle window: never sampled
    vecs.push_back('{4'b1110, 8'hA4, SETTLE - 1, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    vecs.push_back('{4'b1110, 8'hA4, SETTLE - 1, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    // multi-hot anode
    vecs.push_back('{4'b1100, 8'hC0, 20, 16'h0010, 4'b0011, 4'b0000, 0, 1});
    // blank on position 0
    vecs.push_back('{4'b1110, 8'hFF, 20, 16'h0010, 4'b0011, 4'b0000, 0, 0});
    vecs.push_back('{4'b1110, 8'hFF, 20, 16'h0010, 4'b0010, 4'b0000, 1, 0});
    // "1." on position 1: first activation exactly SETTLE cycles long
    vecs.push_back('{4'b1101, 8'h79, SETTLE, 16'h0010, 4'b0010, 4'b0000, 0, 0});
    vecs.push_back('{4'b1101, 8'h79, 20, 16'h0010, 4'b0010, 4'b0010, 1, 0});
`ifdef SEG_HEX_DECODE_EN
    vecs.push_back('{4'b0111, 8'h88, 20, 16'h0010, 4'b0010, 4'b0010, 0, 0});
    vecs.push_back('{4'b0111, 8'h88, 20, 16'hA010, 4'b1010, 4'b0010, 1, 0});
`else
    vecs.push_back('{4'b0111, 8'h88, 20, 16'h0010, 4'b0010, 4'b0010, 0, 1});
    vecs.push_back('{4'b0111, 8'h88, 20, 16'h0010, 4'b0010, 4'b0010, 0, 1});
`endif

    bus.an_val  = '1;
    bus.segment = '1;
    reset       = 1'b1;
    repeat (3) tick();
    check("reset_digits", 32'(bus.digits), 32'h0);
    check("reset_valid", 32'(bus.digit_valid), 32'h0);
    check("reset_dp", 32'(bus.dp), 32'h0);
    check("reset_update", 32'(bus.update), 32'h0);
    check("reset_error", 32'(bus.error), 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset while position 0 is mid-settle.
    bus.an_val  = 4'b1110;
    bus.segment = 8'hC0;
    repeat (2) tick();
    reset      = 1'b1;
    bus.an_val = '1;
    tick();
    check("midreset_digits", 32'(bus.digits), 32'h0);
    check("midreset_valid", 32'(bus.digit_valid), 32'h0);
    check("midreset_dp", 32'(bus.dp), 32'h0);
    check("midreset_update", 32'(bus.update), 32'h0);
    check("midreset_error", 32'(bus.error), 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    // First activation after reset only builds up the candidate.
    u0 = upd_cnt;
    e0 = err_cnt;
    bus.an_val = 4'b1110;
    repeat (20) tick();
    bus.an_val = '1;
    repeat (3) tick();
    check("post_reset_first_valid", 32'(bus.digit_valid), 32'h0);
    check("post_reset_first_updates", upd_cnt - u0, 0);

    // Second activation commits SETTLE+2 edges after the anode edge.
    c.digits = 16'h0000;
    c.valid  = 4'b0001;
    c.dp     = 4'b0000;
    sb_q.push_back(c);
    bus.an_val = 4'b1110;
    repeat (SETTLE + 1) tick();
    check("latency_early_update", 32'(bus.update), 32'h0);
    check("latency_early_valid", 32'(bus.digit_valid), 32'h0);
    tick();
    check("latency_update", 32'(bus.update), 32'h1);
    check("latency_valid", 32'(bus.digit_valid), 32'h1);
    repeat (10) tick();
    bus.an_val = '1;
    repeat (3) tick();
    check("post_reset_updates", upd_cnt - u0, 1);
    check("post_reset_errors", err_cnt - e0, 0);
    check("final_sb_pending", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
